// File: rtl/rowbias_shuffler.sv
// rowbias_shuffler: upstream feeder for the row-bias bus stage.
//
// After reset, and again on each start request, it builds a random
// permutation of the w one-hot values of width w. It uses in-place
// Fisher-Yates with rejection sampling, driven by a free-running 16-bit
// Galois LFSR (x^16+x^14+x^13+x^11+1). It then streams pool entries
// 0..w in order over a valid/ready port. Entry w is always zero.
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous, active-high; loads seed (0 -> 16'hACE1)
//   seed       LFSR seed, sampled only while reset=1
//   start      reshuffle request, honoured only in IDLE
//   out_valid  pool entry presented
//   out_ready  consumer accepts entry this cycle
//   out_index  pool index of presented entry
//   out_value  pool entry value
//   busy       high in any state other than IDLE
//   done       one-cycle pulse after entry w is accepted
//   perm_err   (ROWBIAS_SHUFFLER_SELFCHECK_EN only) sticky permutation error
//
// Optional feature macro: ROWBIAS_SHUFFLER_SELFCHECK_EN adds perm_err and
// an accumulator that checks the emitted stream is a true permutation.

`ifndef GRID_LEN
`define GRID_LEN 4
`endif

module rowbias_shuffler #(
  parameter int w  = `GRID_LEN,
  parameter int LW = 16,
  parameter int IW = $clog2(w + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [LW-1:0] seed,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic [w-1:0]  out_value,
  output logic          busy,
  output logic          done
`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
  ,
  output logic          perm_err
`endif
);

  // Pool select width. cand and i are always < w when they index the pool.
  localparam int PW = (w > 1) ? $clog2(w) : 1;
  localparam logic [IW-1:0] LAST = IW'(w);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SHUFFLE, S_EMIT} state_t;

  state_t              state;
  logic [LW-1:0]       lfsr;
  logic [LW-1:0]       lfsr_nxt;
  logic [w-1:0][w-1:0] pool;
  logic [IW-1:0]       i;
  logic [IW-1:0]       cand;
  logic [IW-1:0]       nxt_idx;

  assign lfsr_nxt = {1'b0, lfsr[LW-1:1]} ^ (lfsr[0] ? LW'(16'hB400) : '0);
  assign cand     = lfsr[IW-1:0];
  assign nxt_idx  = out_index + 1'b1;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock) begin
    done <= 1'b0;
    if (reset) begin
      state     <= S_FILL;
      out_valid <= 1'b0;
      out_index <= '0;
      out_value <= '0;
      lfsr      <= (seed == '0) ? LW'(16'hACE1) : seed;
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        S_FILL: begin
          for (int k = 0; k < w; k++)
            pool[k] <= {{(w-1){1'b0}}, 1'b1} << k;
          i     <= IW'(w - 1);
          state <= S_SHUFFLE;
        end
        S_SHUFFLE: begin
          // Out-of-range candidates are rejected so every swap target is
          // uniform over 0..i.
          if (cand <= i) begin
            pool[i[PW-1:0]]    <= pool[cand[PW-1:0]];
            pool[cand[PW-1:0]] <= pool[i[PW-1:0]];
            i <= i - 1'b1;
            if (i == IW'(1)) begin
              // The last swap touches entry 0 at the same edge that entry 0 is
              // registered, so forward its post-swap value.
              state     <= S_EMIT;
              out_valid <= 1'b1;
              out_index <= '0;
              out_value <= (cand == '0) ? pool[1] : pool[0];
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_index == LAST) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= nxt_idx;
              out_value <= (nxt_idx == LAST) ? '0 : pool[nxt_idx[PW-1:0]];
            end
          end
        end
        S_IDLE: begin
          if (start) state <= S_FILL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
  logic [w-1:0] acc;
  logic         onehot;

  assign onehot = (out_value != '0) && ((out_value & (out_value - 1'b1)) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      perm_err <= 1'b0;
      acc      <= '0;
    end else if (state == S_FILL) begin
      acc <= '0;
    end else if (state == S_EMIT && out_ready) begin
      if (out_index == LAST) begin
        if (out_value != '0 || acc != '1) perm_err <= 1'b1;
      end else begin
        if ((out_value & acc) != '0 || !onehot) perm_err <= 1'b1;
        acc <= acc | out_value;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rowbias_shuffler.sv
`timescale 1ns/1ps
module tb_rowbias_shuffler;
  localparam int W  = 4;
  localparam int IW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   seed = 16'h0001;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [IW-1:0] out_index;
  logic [W-1:0]  out_value;
  logic          busy;
  logic          done;
`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
  logic          perm_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rowbias_shuffler #(.w(W)) dut (
    .clock(clock), .reset(reset), .seed(seed), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_value(out_value), .busy(busy), .done(done)
`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
    , .perm_err(perm_err)
`endif
  );

  // Reference LFSR, free-running exactly like the block's.
  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clock)
    if (reset) m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
    else       m_lfsr <= adv(m_lfsr);

  // Permutation model; v is the LFSR value seen the cycle before FILL.
  logic [W-1:0]  mp [W];
  int            msh;
  logic [IW-1:0] exp_idx[$];
  logic [W-1:0]  exp_val[$];

  task automatic model_run(input logic [15:0] v);
    logic [15:0] l;
    logic [W-1:0] t;
    int ii, c;
    for (int k = 0; k < W; k++) mp[k] = W'(1 << k);
    l = adv(v); ii = W - 1; msh = 0;
    while (ii >= 1) begin
      c = int'(l[IW-1:0]);
      if (c <= ii) begin t = mp[ii]; mp[ii] = mp[c]; mp[c] = t; ii--; end
      l = adv(l); msh++;
    end
    exp_idx.delete(); exp_val.delete();
    for (int k = 0; k < W; k++) begin exp_idx.push_back(IW'(k)); exp_val.push_back(mp[k]); end
    exp_idx.push_back(IW'(W)); exp_val.push_back('0);
  endtask

  // Per-cycle trace captured at negedges until done is seen.
  bit            tr_v[$], tr_r[$];
  logic [IW-1:0] tr_i[$];
  logic [W-1:0]  tr_val[$];

  task automatic collect(input int maxc, input logic [15:0] pat, input int plen, output bit ok);
    int p;
    bit fin;
    p = 0; fin = 0;
    tr_v.delete(); tr_r.delete(); tr_i.delete(); tr_val.delete();
    for (int n = 0; n < maxc && !fin; n++) begin
      out_ready = (out_valid && p < plen) ? pat[p] : 1'b1;
      if (out_valid) p++;
      tr_v.push_back(out_valid); tr_r.push_back(out_ready);
      tr_i.push_back(out_index); tr_val.push_back(out_value);
      if (done) fin = 1;
      else @(negedge clock);
    end
    ok = fin;
  endtask

  task automatic do_reset(input logic [15:0] s);
    reset = 1'b1; seed = s; start = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; seed = 16'h0001;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_index !== '0) begin failures++; $display("FAIL reset_index got=%0d exp=0", out_index); end
    checks++; if (out_value !== '0) begin failures++; $display("FAIL reset_value got=%h exp=0", out_value); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    int first, last, dcyc, pc;
    logic [W-1:0] orv;
    logic [IW-1:0] ei;
    logic [W-1:0] ev;
    do_reset(16'h0001);
    model_run(m_lfsr);
    collect(500, 16'h0, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    first = -1; last = -1; dcyc = tr_v.size() - 1; pc = 0; orv = '0;
    for (int n = 0; n < tr_v.size(); n++) begin
      if (tr_v[n] && first < 0) first = n;
      if (tr_v[n] && tr_r[n]) begin
        last = n;
        if (tr_i[n] < IW'(W)) begin orv |= tr_val[n]; pc += $countones(tr_val[n]); end
        checks++;
        if (exp_idx.size() == 0) begin failures++; $display("FAIL basic_extra_beat got=%0d exp=none", tr_i[n]); end
        else begin
          ei = exp_idx.pop_front(); ev = exp_val.pop_front();
          if (tr_i[n] !== ei || tr_val[n] !== ev) begin
            failures++; $display("FAIL basic_beat got=%0d/%h exp=%0d/%h", tr_i[n], tr_val[n], ei, ev);
          end
        end
      end
    end
    checks++; if (exp_idx.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d_left exp=0", exp_idx.size()); end
    checks++; if (first != 1 + msh) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", first, 1 + msh); end
    checks++; if (last - first != W) begin failures++; $display("FAIL basic_throughput got=%0d exp=%0d", last - first, W); end
    checks++; if (dcyc != last + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", dcyc, last + 1); end
    checks++; if (orv !== {W{1'b1}} || pc != W) begin failures++; $display("FAIL basic_perm got=%h/%0d exp=%h/%0d", orv, pc, {W{1'b1}}, W); end
    @(negedge clock);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int nb, ns, nv;
    logic [IW-1:0] ei;
    logic [W-1:0] ev;
    do_reset(16'h00A5);
    model_run(m_lfsr);
    collect(500, 16'h00E9, 8, ok);  // ready 1,0,0,1,0,1,1,1
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    nb = 0; ns = 0; nv = 0;
    for (int n = 0; n < tr_v.size(); n++) begin
      if (tr_v[n]) nv++;
      if (tr_v[n] && !tr_r[n] && n + 1 < tr_v.size()) begin
        ns++;
        checks++;
        if (!tr_v[n+1] || tr_i[n+1] !== tr_i[n] || tr_val[n+1] !== tr_val[n]) begin
          failures++; $display("FAIL bp_stall_hold got=%0d/%h exp=%0d/%h", tr_i[n+1], tr_val[n+1], tr_i[n], tr_val[n]);
        end
      end
      if (tr_v[n] && tr_r[n]) begin
        nb++;
        checks++;
        if (exp_idx.size() == 0) begin failures++; $display("FAIL bp_extra_beat got=%0d exp=none", tr_i[n]); end
        else begin
          ei = exp_idx.pop_front(); ev = exp_val.pop_front();
          if (tr_i[n] !== ei || tr_val[n] !== ev) begin
            failures++; $display("FAIL bp_beat got=%0d/%h exp=%0d/%h", tr_i[n], tr_val[n], ei, ev);
          end
        end
      end
    end
    checks++; if (nb != W + 1) begin failures++; $display("FAIL bp_beats got=%0d exp=%0d", nb, W + 1); end
    checks++; if (ns != 3 || nv != 8) begin failures++; $display("FAIL bp_stalls got=%0d/%0d exp=3/8", ns, nv); end
  endtask

  task automatic test_seed_zero();
    bit ok0, ok1;
    bit a_v[$];
    logic [IW-1:0] a_i[$];
    logic [W-1:0] a_val[$];
    int bad;
    do_reset(16'h0000);
    collect(500, 16'h0, 0, ok0);
    a_v = tr_v; a_i = tr_i; a_val = tr_val;
    do_reset(16'hACE1);
    collect(500, 16'h0, 0, ok1);
    checks++; if (!ok0 || !ok1) begin failures++; $display("FAIL seed0_timeout got=%b%b exp=11", ok0, ok1); end
    checks++; if (a_v.size() != tr_v.size()) begin failures++; $display("FAIL seed0_length got=%0d exp=%0d", a_v.size(), tr_v.size()); end
    else begin
      bad = 0;
      for (int n = 0; n < tr_v.size(); n++)
        if (a_v[n] !== tr_v[n] || a_i[n] !== tr_i[n] || a_val[n] !== tr_val[n]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL seed0_trace got=%0d_diffs exp=0", bad); end
    end
  endtask

  task automatic test_restart();
    bit ok;
    int n, nb;
    logic [IW-1:0] ei;
    logic [W-1:0] ev;
    do_reset(16'h0001);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 500) begin @(negedge clock); n++; end
    checks++; if (!out_valid) begin failures++; $display("FAIL restart_emit_timeout got=0 exp=1"); end
    start = 1'b1; @(negedge clock); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_index !== '0) begin
      failures++; $display("FAIL restart_start_in_emit got=%b%b%0d exp=110", busy, out_valid, out_index);
    end
    out_ready = 1'b1; n = 0; nb = 0;
    while (!done && n < 50) begin
      if (out_valid) nb++;
      @(negedge clock); n++;
    end
    checks++; if (!done || nb != W + 1) begin failures++; $display("FAIL restart_first_run got=%b/%0d exp=1/%0d", done, nb, W + 1); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_not_queued got=%b exp=0", busy); end
    start = 1'b1; @(negedge clock); start = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL restart_fill got=%b%b exp=10", busy, out_valid); end
    model_run(m_lfsr);
    collect(500, 16'h0, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
    for (int k = 0; k < tr_v.size(); k++)
      if (tr_v[k] && tr_r[k]) begin
        checks++;
        if (exp_idx.size() == 0) begin failures++; $display("FAIL restart_extra_beat got=%0d exp=none", tr_i[k]); end
        else begin
          ei = exp_idx.pop_front(); ev = exp_val.pop_front();
          if (tr_i[k] !== ei || tr_val[k] !== ev) begin
            failures++; $display("FAIL restart_beat got=%0d/%h exp=%0d/%h", tr_i[k], tr_val[k], ei, ev);
          end
        end
      end
    checks++; if (exp_idx.size() != 0) begin failures++; $display("FAIL restart_missing got=%0d_left exp=0", exp_idx.size()); end
    // start coinciding with the done pulse is honoured
    start = 1'b1; @(negedge clock); start = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL restart_on_done got=%b%b exp=10", busy, out_valid); end
  endtask

  task automatic test_reset_mid_shuffle();
    bit ok;
    int first;
    logic [IW-1:0] ei;
    logic [W-1:0] ev;
    do_reset(16'h0001);
    repeat (3) @(negedge clock);  // third SHUFFLE cycle
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_in_shuffle got=%b%b exp=10", busy, out_valid); end
    reset = 1'b1; seed = 16'h1234;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out_index !== '0) begin
      failures++; $display("FAIL mid_reset_state got=%b%b%0d exp=010", out_valid, busy, out_index);
    end
    reset = 1'b0;
    model_run(m_lfsr);
    collect(500, 16'h0, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=no_done exp=done"); end
    first = -1;
    for (int n = 0; n < tr_v.size(); n++) begin
      if (tr_v[n] && first < 0) first = n;
      if (tr_v[n] && tr_r[n]) begin
        checks++;
        if (exp_idx.size() == 0) begin failures++; $display("FAIL mid_extra_beat got=%0d exp=none", tr_i[n]); end
        else begin
          ei = exp_idx.pop_front(); ev = exp_val.pop_front();
          if (tr_i[n] !== ei || tr_val[n] !== ev) begin
            failures++; $display("FAIL mid_beat got=%0d/%h exp=%0d/%h", tr_i[n], tr_val[n], ei, ev);
          end
        end
      end
    end
    checks++; if (first != 1 + msh) begin failures++; $display("FAIL mid_latency got=%0d exp=%0d", first, 1 + msh); end
  endtask

`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
  logic          r9 = 1'b1, st9 = 1'b0, rdy9 = 1'b1;
  logic [15:0]   sd9 = 16'h0BAD;
  logic          v9, busy9, done9, err9;
  logic [3:0]    i9;
  logic [8:0]    val9;

  rowbias_shuffler #(.w(9)) dut9 (
    .clock(clock), .reset(r9), .seed(sd9), .start(st9),
    .out_valid(v9), .out_ready(rdy9), .out_index(i9),
    .out_value(val9), .busy(busy9), .done(done9), .perm_err(err9)
  );

  task automatic test_selfcheck();
    int n, runs;
    logic [8:0][8:0] pv;
    checks++; if (perm_err !== 1'b0) begin failures++; $display("FAIL sc_w4_err got=%b exp=0", perm_err); end
    r9 = 1'b1; @(negedge clock); r9 = 1'b0; rdy9 = 1'b1; runs = 0;
    for (int r = 0; r < 100; r++) begin
      n = 0;
      while (!done9 && n < 2000) begin @(negedge clock); n++; end
      if (done9) runs++;
      st9 = 1'b1; @(negedge clock); st9 = 1'b0;
    end
    checks++; if (runs != 100) begin failures++; $display("FAIL sc_runs got=%0d exp=100", runs); end
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL sc_clean got=%b exp=0", err9); end
    rdy9 = 1'b0; n = 0;
    while (!v9 && n < 2000) begin @(negedge clock); n++; end
    rdy9 = 1'b1; @(negedge clock); rdy9 = 1'b0;  // accept index 0
    pv = dut9.pool; pv[2] = pv[1];
    force dut9.pool = pv;
    rdy9 = 1'b1; @(negedge clock); rdy9 = 1'b0;  // accept index 1, load corrupt 2
    release dut9.pool;
    checks++; if (err9 !== 1'b0 || i9 !== 4'd2) begin failures++; $display("FAIL sc_pre_dup got=%b/%0d exp=0/2", err9, i9); end
    rdy9 = 1'b1; @(negedge clock);
    checks++; if (err9 !== 1'b1) begin failures++; $display("FAIL sc_dup got=%b exp=1", err9); end
    n = 0;
    while (!done9 && n < 50) begin @(negedge clock); n++; end
    st9 = 1'b1; @(negedge clock); st9 = 1'b0; n = 0;
    while (!done9 && n < 2000) begin @(negedge clock); n++; end
    checks++; if (err9 !== 1'b1 || !done9) begin failures++; $display("FAIL sc_sticky got=%b/%b exp=1/1", err9, done9); end
    r9 = 1'b1; @(negedge clock); r9 = 1'b0;
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL sc_reset_clear got=%b exp=0", err9); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_backpressure();
    test_seed_zero();
    test_restart();
    test_reset_mid_shuffle();
`ifdef ROWBIAS_SHUFFLER_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rowbias_shuffler.md
Name: rowbias_shuffler

Overview:
- Upstream feeder for the row-bias bus stage.
- After every reset, and on request, generates a fresh random permutation of the w one-hot values of width w.
- Streams the pool entries in index order (0..w) to the row-bias pool write port; entry w is always all-zeros.
- One instance per grid row; all instances share a clock, each gets its own seed.

Parameters:
- w, `GRID_LEN, bus width / number of one-hot values (>=2).
- LW, 16, LFSR width (fixed polynomial below; only 16 supported).
- IW, $clog2(w+1), index width.

Ports:
- clock  in  1  Single clock; all logic on rising edge.
- reset  in  1  Synchronous, active-high.
- seed  in  LW  LFSR seed, sampled only while reset=1.
- start  in  1  Request a reshuffle; honoured only in IDLE.
- out_valid  out  1  Pool entry presented.
- out_ready  in  1  Consumer accepts entry this cycle.
- out_index  out  IW  Pool index of the presented entry.
- out_value  out  w  Pool entry value.
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse after the last entry is accepted.

Behaviour:
- Reset (reset=1 at posedge):
  - state<=FILL; out_valid=0, out_index=0, out_value=0, done=0.
  - lfsr<=seed, or 16'hACE1 if seed==0.
  - Reset wins over all other inputs, including mid-SHUFFLE or mid-EMIT; the partial permutation is discarded.
- LFSR: Galois, taps x^16+x^14+x^13+x^11+1. Advances every non-reset cycle in every state (free-running). Never zero.
- Internal pool: w entries, each w bits. Loop counter i is IW bits wide.
- FILL (1 cycle): pool[k]<=1<<k for all k; i<=w-1; ->SHUFFLE.
- SHUFFLE (Fisher-Yates with rejection sampling):
  - Each cycle, cand=lfsr[IW-1:0] (current value, before advance).
  - If cand<=i: swap pool[i] and pool[cand] (cand==i is a legal no-op), i<=i-1. If i was 1: ->EMIT with k=0.
  - Else: reject; retry next cycle with the new lfsr value.
  - Latency: w-1 accepts plus a variable number of rejects.
- EMIT:
  - out_valid=1; out_index=k; out_value=pool[k] for k<w, 0 for k==w.
  - Outputs are registered and held stable while out_valid & !out_ready.
  - On out_valid & out_ready: k<=k+1. If k==w: ->IDLE, out_valid<=0, done<=1 for one cycle.
  - Throughput: 1 entry/cycle when out_ready=1 continuously.
- IDLE:
  - busy=0; pool retained.
  - start=1 -> FILL next cycle.
  - start outside IDLE is ignored (not queued).
  - start on the same cycle as the done pulse is honoured, because the state is already IDLE.
- Across all emitted entries 0..w-1, the OR equals all ones and the entries are pairwise disjoint.

Optional Feature:
- Macro ROWBIAS_SHUFFLER_SELFCHECK_EN.
- Defined:
  - Adds output port perm_err (1 bit, reset 0).
  - During EMIT, accumulates acc|=out_value on each accepted entry with k<w.
  - Sets perm_err sticky if an accepted entry overlaps acc, or is not one-hot (k<w), or if entry w is nonzero.
  - At the last accept, also sets perm_err if acc != all ones.
  - acc clears on FILL. perm_err clears only on reset.
- Not defined: no perm_err port, no accumulator logic; all other behaviour is identical.

Test Plan:
- w=4, seed=16'h0001, out_ready=1: after FILL plus shuffle, 5 beats with out_index 0,1,2,3,4; values 0..3 are a permutation of {1,2,4,8} matching the bench LFSR model; index 4 value 0; done high exactly 1 cycle after the index-4 beat.
- Backpressure, w=4: out_ready pattern 1,0,0,1,0,1,1,1: out_index/out_value constant while stalled; exactly 5 accepted beats; no duplicates or skips.
- seed=0 vs seed=16'hACE1: cycle-identical output sequences.
- After first done, w=4 seed=1: pulse start in EMIT (ignored, busy stays 1), then start in IDLE -> FILL next cycle; second permutation equals the model's next permutation.
- reset asserted in cycle 3 of SHUFFLE: next cycle out_valid=0, busy=1, state FILL; sequence afterwards equals a fresh run from the new seed.
- With ROWBIAS_SHUFFLER_SELFCHECK_EN: perm_err stays 0 across 100 reshuffles at w=9; a forced pool corruption (bench force: pool[2]=pool[1]) sets perm_err on the duplicate beat and holds it until reset.
